// File: rtl/uvma_rvfi_retire_pkg.sv
// Shared RVFI retire record definitions.
// Contents: NRET_MAX lane limit, widest supported PC, and the per-lane
// retire record carried on every lane and out of the buffer head.
package uvma_rvfi_retire_pkg;

    localparam int unsigned NRET_MAX = 8;
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned ORDER_W  = 64;
    localparam int unsigned INSN_W   = 32;

    // One retired instruction; pc_rdata is sized for the widest XLEN and
    // narrower configurations keep the upper bits at zero.
    typedef struct packed {
        logic [ORDER_W-1:0]  order;
        logic [INSN_W-1:0]   insn;
        logic [XLEN_MAX-1:0] pc_rdata;
        logic                trap;
        logic                halt;
    } rvfi_entry_t;

endpackage

// File: rtl/reference_model_lane_compact.sv
// Lane compaction: prefix count over the lane valid mask.
// Ports:
//   i_valid  - per-lane candidate mask, lane 0 first
//   o_offset - per-lane slot offset (number of set lanes below it)
//   o_count  - total number of set lanes
module reference_model_lane_compact #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned CNT_W = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]            i_valid,
    output logic [NRET-1:0][CNT_W-1:0] o_offset,
    output logic [CNT_W-1:0]           o_count
);

    logic [CNT_W-1:0] w_run;

    // Running sum: each lane's offset is the count of lower set lanes.
    always_comb begin
        w_run    = '0;
        o_offset = '0;
        for (int i = 0; i < NRET; i++) begin
            o_offset[i] = w_run;
            w_run       = w_run + CNT_W'(i_valid[i]);
        end
        o_count = w_run;
    end

endmodule

// File: rtl/reference_model_retire_buffer.sv
// Retire buffer: collects up to NRET RVFI retire lanes per cycle into a
// DEPTH-entry in-order queue, checks order continuity and stops at halt.
// Ports:
//   clk_i, rst_ni              - clock, async active-low reset
//   rvfi_valid_i/rvfi_entry_i  - per-lane retire records, lane 0 oldest
//   flush_i                    - synchronous clear of queue and halt state
//   out_valid_o/out_entry_o    - registered head of queue
//   out_ready_i                - consumer pops head when valid
//   count_o                    - occupied entries
//   overflow_o, order_err_o    - sticky error flags (reset only)
//   halt_seen_o                - halt entry accepted since last flush
module reference_model_retire_buffer
    import uvma_rvfi_retire_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRET-1:0]            rvfi_valid_i,
    input  rvfi_entry_t [NRET-1:0]     rvfi_entry_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    output rvfi_entry_t                out_entry_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       order_err_o,
    output logic                       halt_seen_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LANE_W = $clog2(NRET + 1);
    localparam logic [XLEN_MAX-1:0] PC_MASK =
        (XLEN >= XLEN_MAX) ? '1 : ((XLEN_MAX'(1) << XLEN) - XLEN_MAX'(1));

    rvfi_entry_t          r_mem [DEPTH];
    rvfi_entry_t          r_head;
    logic                 r_out_valid;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [ORDER_W-1:0]   r_exp_order;
    logic                 r_overflow;
    logic                 r_order_err;
    logic                 r_halt_seen;

    rvfi_entry_t                  w_lane_entry [NRET];
    logic [NRET-1:0]              w_cand;
    logic                         w_cut;
    logic [NRET-1:0][LANE_W-1:0]  w_offset;
    logic [LANE_W-1:0]            w_cand_cnt;
    logic [NRET-1:0]              w_acc;
    logic [PTR_W-1:0]             w_slot [NRET];
    logic                         w_pop;
    logic [CNT_W-1:0]             w_free;
    logic                         w_drop;
    logic [CNT_W-1:0]             w_n_wr;
    logic [CNT_W-1:0]             w_rem;
    logic [CNT_W-1:0]             w_count_nxt;
    logic [PTR_W-1:0]             w_rd_nxt;
    logic [PTR_W-1:0]             w_wr_nxt;
    logic [ORDER_W-1:0]           w_exp;
    logic                         w_err;
    logic                         w_halt;
    rvfi_entry_t                  w_first;
    rvfi_entry_t                  w_head_nxt;

    // Clip PC to the configured XLEN.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            w_lane_entry[i]          = rvfi_entry_i[i];
            w_lane_entry[i].pc_rdata = rvfi_entry_i[i].pc_rdata & PC_MASK;
        end
    end

    // Candidates: valid lanes up to and including the first halt lane;
    // nothing once a halt has been accepted. Lanes cut here never count
    // as overflow.
    always_comb begin
        w_cand = '0;
        w_cut  = r_halt_seen;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi_valid_i[i] && !w_cut) begin
                w_cand[i] = 1'b1;
                if (rvfi_entry_i[i].halt) begin
                    w_cut = 1'b1;
                end
            end
        end
    end

    reference_model_lane_compact #(
        .NRET  (NRET),
        .CNT_W (LANE_W)
    ) u_compact (
        .i_valid  (w_cand),
        .o_offset (w_offset),
        .o_count  (w_cand_cnt)
    );

    // Space includes the slot freed by a same-cycle pop.
    assign w_pop       = r_out_valid & out_ready_i;
    assign w_free      = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
    assign w_drop      = 32'(w_cand_cnt) > 32'(w_free);
    assign w_n_wr      = w_drop ? w_free : CNT_W'(w_cand_cnt);
    assign w_rem       = r_count - CNT_W'(w_pop);
    assign w_count_nxt = w_rem + w_n_wr;
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
    assign w_wr_nxt    = r_wr_ptr + PTR_W'(w_n_wr);

    // Lowest-offset candidates that fit are written; slots wrap mod DEPTH.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            w_acc[i]  = w_cand[i] && (32'(w_offset[i]) < 32'(w_free));
            w_slot[i] = r_wr_ptr + PTR_W'(w_offset[i]);
        end
    end

    // Order continuity with resync, halt detection, and the first written
    // entry (needed when it becomes the head immediately).
    always_comb begin
        w_exp   = r_exp_order;
        w_err   = 1'b0;
        w_halt  = 1'b0;
        w_first = w_lane_entry[0];
        for (int i = 0; i < NRET; i++) begin
            if (w_acc[i]) begin
                if (w_lane_entry[i].order != w_exp) begin
                    w_err = 1'b1;
                end
                w_exp = w_lane_entry[i].order + ORDER_W'(1);
                if (w_lane_entry[i].halt) begin
                    w_halt = 1'b1;
                end
                if (w_offset[i] == '0) begin
                    w_first = w_lane_entry[i];
                end
            end
        end
    end

    // Head comes from this cycle's writes when the queue drains to empty.
    assign w_head_nxt = (w_rem == '0) ? w_first : r_mem[w_rd_nxt];

    // Control state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_exp_order <= '0;
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
            r_halt_seen <= 1'b0;
            r_head      <= '0;
        end else if (flush_i) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_halt_seen <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_rd_ptr    <= w_rd_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_exp_order <= w_exp;
            r_overflow  <= r_overflow | w_drop;
            r_order_err <= r_order_err | w_err;
            r_halt_seen <= r_halt_seen | w_halt;
            r_head      <= w_head_nxt;
        end
    end

    // Entry storage; contents are meaningless outside [rd_ptr, rd_ptr+count).
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int i = 0; i < NRET; i++) begin
                if (w_acc[i]) begin
                    r_mem[w_slot[i]] <= w_lane_entry[i];
                end
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_entry_o = r_head;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;
    assign order_err_o = r_order_err;
    assign halt_seen_o = r_halt_seen;

endmodule

// File: tb/tb_reference_model_retire_buffer.sv
// Bench for reference_model_retire_buffer: queue-based behavioural model
// compared every cycle, plus literal expectations for directed scenarios.
module tb_reference_model_retire_buffer;
    import uvma_rvfi_retire_pkg::*;

    localparam int unsigned NRET  = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst_ni;
    logic [NRET-1:0]       valid;
    rvfi_entry_t [NRET-1:0] ent;
    logic                  flush;
    logic                  out_valid;
    rvfi_entry_t           out_entry;
    logic                  out_ready;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  order_err;
    logic                  halt_seen;

    int n_checks = 0;
    int n_errors = 0;

    rvfi_entry_t  mq[$];
    logic [63:0]  m_exp;
    logic         m_ovf, m_err, m_halt;
    logic [63:0]  popped[$];

    reference_model_retire_buffer #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rvfi_valid_i (valid),
        .rvfi_entry_i (ent),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_entry_o  (out_entry),
        .out_ready_i  (out_ready),
        .count_o      (count),
        .overflow_o   (overflow),
        .order_err_o  (order_err),
        .halt_seen_o  (halt_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rvfi_entry_t mk(input logic [63:0] o, input logic h);
        rvfi_entry_t e;
        e.order    = o;
        e.insn     = 32'h0000_0013 ^ (o[31:0] << 7);
        e.pc_rdata = 64'(32'h8000_0000 + o[31:0] * 32'd4);
        e.trap     = o[0];
        e.halt     = h;
        return e;
    endfunction

    // Model: queue of accepted entries, lanes taken oldest first while there
    // is room, halt stops acceptance until flush.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_exp  = '0;
            m_ovf  = 1'b0;
            m_err  = 1'b0;
            m_halt = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_halt = 1'b0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            for (int i = 0; i < NRET; i++) begin
                if (valid[i] && !m_halt) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(ent[i]);
                        if (ent[i].order != m_exp) m_err = 1'b1;
                        m_exp = ent[i].order + 64'd1;
                        if (ent[i].halt) m_halt = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("order_err", 64'(order_err), 64'(m_err));
            chk("halt_seen", 64'(halt_seen), 64'(m_halt));
            if (mq.size() > 0) begin
                chk("head.order", out_entry.order, mq[0].order);
                chk("head.insn", 64'(out_entry.insn), 64'(mq[0].insn));
                chk("head.pc", out_entry.pc_rdata, mq[0].pc_rdata);
                chk("head.trap", 64'(out_entry.trap), 64'(mq[0].trap));
                chk("head.halt", 64'(out_entry.halt), 64'(mq[0].halt));
            end
            if (out_valid && out_ready) popped.push_back(out_entry.order);
        end
    end

    // Drive one cycle of inputs, return just after the consuming edge.
    task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic h0,
                        input logic [63:0] o1, input logic h1, input logic rdy, input logic fl);
        valid     = v;
        ent[0]    = mk(o0, h0);
        ent[1]    = mk(o1, h1);
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int k = 0; k < n; k++) step(2'b00, 64'd0, 1'b0, 64'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        valid     = '0;
        ent       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_ni    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        popped.delete();
    endtask

    initial begin
        rst_ni = 1'b1;
        #2;
        do_reset();
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.flags", 64'({overflow, order_err, halt_seen}), 64'd0);

        // Two lanes, drained in order on consecutive cycles.
        step(2'b11, 64'd0, 1'b0, 64'd1, 1'b0, 1'b1, 1'b0);
        chk("t1.count", 64'(count), 64'd2);
        idle(1'b1, 3);
        chk("t1.npop", 64'(popped.size()), 64'd2);
        if (popped.size() == 2) begin
            chk("t1.pop0", popped[0], 64'd0);
            chk("t1.pop1", popped[1], 64'd1);
        end
        chk("t1.err", 64'({overflow, order_err}), 64'd0);

        // Non-contiguous lanes are compacted.
        do_reset();
        step(2'b10, 64'd99, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 64'd1, 1'b0, 64'd77, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("t2.npop", 64'(popped.size()), 64'd2);
        if (popped.size() == 2) begin
            chk("t2.pop0", popped[0], 64'd0);
            chk("t2.pop1", popped[1], 64'd1);
        end
        chk("t2.err", 64'(order_err), 64'd0);

        // Overflow with consumer stalled.
        do_reset();
        for (int k = 0; k < 5; k++)
            step(2'b11, 64'(2 * k), 1'b0, 64'(2 * k + 1), 1'b0, 1'b0, 1'b0);
        chk("t3.count", 64'(count), 64'd8);
        chk("t3.ovf", 64'(overflow), 64'd1);
        chk("t3.err", 64'(order_err), 64'd0);
        idle(1'b1, 10);
        chk("t3.npop", 64'(popped.size()), 64'd8);
        for (int k = 0; k < popped.size(); k++) chk("t3.pop", popped[k], 64'(k));

        // Order break sets the sticky error on the offending write only.
        do_reset();
        step(2'b11, 64'd0, 1'b0, 64'd1, 1'b0, 1'b1, 1'b0);
        chk("t4.err0", 64'(order_err), 64'd0);
        step(2'b11, 64'd5, 1'b0, 64'd6, 1'b0, 1'b1, 1'b0);
        chk("t4.err1", 64'(order_err), 64'd1);
        step(2'b01, 64'd7, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 4);
        chk("t4.err2", 64'(order_err), 64'd1);

        // Halt stops acceptance until flush; flush drops same-cycle traffic.
        do_reset();
        step(2'b11, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
        chk("t5.count", 64'(count), 64'd1);
        chk("t5.halt", 64'(halt_seen), 64'd1);
        chk("t5.head", out_entry.order, 64'd0);
        step(2'b11, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
        chk("t5.count2", 64'(count), 64'd1);
        chk("t5.ovf", 64'(overflow), 64'd0);
        step(2'b11, 64'd5, 1'b0, 64'd6, 1'b0, 1'b1, 1'b1);
        chk("t5.fcount", 64'(count), 64'd0);
        chk("t5.fhalt", 64'(halt_seen), 64'd0);
        chk("t5.fvalid", 64'(out_valid), 64'd0);
        step(2'b01, 64'd1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("t5.after", 64'(count), 64'd1);
        chk("t5.aerr", 64'(order_err), 64'd0);

        // Full buffer, pop and write each cycle across the pointer wrap.
        do_reset();
        for (int k = 0; k < 4; k++)
            step(2'b11, 64'(2 * k), 1'b0, 64'(2 * k + 1), 1'b0, 1'b0, 1'b0);
        chk("t6.full", 64'(count), 64'd8);
        for (int k = 8; k < 14; k++) begin
            step(2'b01, 64'(k), 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            chk("t6.count", 64'(count), 64'd8);
        end
        idle(1'b1, 10);
        chk("t6.npop", 64'(popped.size()), 64'd14);
        for (int k = 0; k < popped.size(); k++) chk("t6.pop", popped[k], 64'(k));
        chk("t6.flags", 64'({overflow, order_err}), 64'd0);

        // Asynchronous reset in the middle of a burst.
        step(2'b11, 64'd14, 1'b0, 64'd15, 1'b0, 1'b0, 1'b0);
        step(2'b11, 64'd16, 1'b0, 64'd17, 1'b0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7.count", 64'(count), 64'd0);
        chk("t7.valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        step(2'b01, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("t7.count1", 64'(count), 64'd1);
        chk("t7.head", out_entry.order, 64'd0);
        idle(1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reference_model_retire_buffer.md
REFERENCE_MODEL_RETIRE_BUFFER -- requirements
Module: reference_model_retire_buffer

Interface
REQ-001 SHALL have parameter NRET, default 2, meaning the number of parallel RVFI retire lanes (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of entries in the buffer (power of 2, DEPTH >= NRET).
REQ-003 SHALL have parameter XLEN, default 32, meaning the width of the PC field.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 rvfi_valid_i  input  NRET  per-lane retire valid; lane 0 is the oldest.
REQ-007 rvfi_entry_i  input  NRET x rvfi_entry_t  per-lane record: order[63:0], insn[31:0], pc_rdata[XLEN-1:0], trap, halt.
REQ-008 flush_i  input  1  synchronous buffer clear.
REQ-009 out_valid_o  output  1  head entry available.
REQ-010 out_entry_o  output  rvfi_entry_t  head entry, oldest first.
REQ-011 out_ready_i  input  1  consumer accepts the head entry.
REQ-012 count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 overflow_o  output  1  sticky: a valid lane was dropped.
REQ-014 order_err_o  output  1  sticky: order sequence broken.
REQ-015 halt_seen_o  output  1  an entry with halt=1 has been accepted since the last flush.

Function
REQ-016 Valid lanes SHALL be written in ascending lane index into consecutive slots; non-contiguous valid lanes are compacted, with no holes.
REQ-017 A written entry SHALL appear on out_entry_o no earlier than the cycle after the write, giving a minimum latency of 1 cycle.
REQ-018 out_valid_o SHALL equal (count_o != 0); out_entry_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-019 A pop SHALL occur when out_valid_o=1 and out_ready_i=1; a pop and writes in the same cycle SHALL both take effect: count_next = count - pop + writes.
REQ-020 Free space for writes SHALL be computed as DEPTH - count + pop, so a simultaneous pop frees one slot for the same cycle.
REQ-021 When valid lanes exceed free space, the lowest-index lanes that fit SHALL be written and the remainder dropped, setting overflow_o.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; a full buffer (count=DEPTH) with a pop and one write SHALL stay full with correct ordering.
REQ-023 An expected-order register SHALL check each written entry: if order != expected, set order_err_o; in both cases set expected = order+1 (resync).
REQ-024 Dropped lanes SHALL NOT update expected-order.
REQ-025 After an entry with halt=1 is written, all later lanes in the same cycle and all lanes in later cycles SHALL be ignored until flush, without setting overflow_o.
REQ-026 flush_i=1 SHALL, in the next cycle: set count_o=0, reset both pointers, clear halt_seen_o, and drop all same-cycle inputs and the same-cycle pop.
REQ-027 flush_i SHALL NOT clear overflow_o, order_err_o or expected-order.

Reset
REQ-028 On rst_ni=0, the following SHALL clear asynchronously to 0: count_o, out_valid_o, pointers, expected-order, overflow_o, order_err_o and halt_seen_o; out_entry_o is don't-care while out_valid_o=0.
REQ-029 Reset asserted mid-burst SHALL discard all buffered entries; the first cycle after deassertion SHALL accept input normally.

Structure
REQ-030 The rvfi_entry_t struct and the NRET_MAX=8 constant SHALL reside in a shared package uvma_rvfi_retire_pkg.
REQ-031 Lane compaction SHALL be one sub-module, reference_model_lane_compact: a combinational prefix-count producing a slot offset per lane and the write count.
REQ-032 Storage SHALL be a flop array; no SRAM macro.

Verification
REQ-033 Reset, then lanes 0,1 valid with orders 0,1 and out_ready_i=1: entries appear on consecutive cycles, orders 0 then 1; both error flags stay 0.
REQ-034 Only lane 1 valid (order 0) then only lane 0 valid (order 1): the entries are compacted and output orders are 0, 1.
REQ-035 DEPTH=8, out_ready_i=0, drive 5 cycles of both lanes: count_o=8 and overflow_o=1; draining outputs orders 0..7 only.
REQ-036 Write orders 0,1,5,6: order_err_o sets on the cycle order 5 is written; no further error is raised on 6.
REQ-037 Lane 0 carries halt=1 with lane 1 valid: only lane 0 is stored, halt_seen_o=1, and later inputs are ignored; flush_i then gives count_o=0 and halt_seen_o=0.
REQ-038 Full buffer with pop and one write in the same cycle: count_o stays 8 and output order stays contiguous across pointer wrap.
